// File: rtl/mac_ofifo_pkg.sv
// Purpose : shared defaults for the MAC output collector.
// Contents: default column count, partial-sum width and per-column FIFO
//           depth. mac_ofifo uses these as its parameter defaults so that
//           integrators and the bench agree on one set of numbers.
package mac_ofifo_pkg;

  localparam int MAC_OFIFO_COL     = 8;
  localparam int MAC_OFIFO_PSUM_BW = 16;
  localparam int MAC_OFIFO_DEPTH   = 16;

endpackage : mac_ofifo_pkg

// File: rtl/ofifo_col.sv
// Purpose : single-column FIFO for the MAC output collector.
// Ports   : clk   - clock, all state updates on posedge
//           reset - asynchronous active-low reset (pointers and ovf only)
//           wr    - write strobe; data accepted unless full (or full but popped)
//           din   - partial sum to store
//           rd    - pop request; ignored while empty
//           dout  - show-ahead head entry (storage at rd pointer)
//           empty - no entries held
//           full  - depth entries held
//           ovf   - sticky flag: a write to a full FIFO was dropped
module ofifo_col #(
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic [psum_bw-1:0] din,
  input  logic               rd,
  output logic [psum_bw-1:0] dout,
  output logic               empty,
  output logic               full,
  output logic               ovf
);

  localparam int AW = $clog2(depth);
  // One extra wrap bit tells full from empty when the index bits match.
  localparam int PW = AW + 1;

  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic               ovf_q, ovf_d;
  logic [psum_bw-1:0] mem_q [depth];
  logic               do_rd;
  logic               do_wr;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = ((rd_ptr_q ^ wr_ptr_q) == {1'b1, {AW{1'b0}}});

  assign do_rd = rd & ~empty;
  // A pop in the same cycle frees the head slot, so a full column still
  // accepts the write; empty-and-pop cannot occur because do_rd needs data.
  assign do_wr = wr & (~full | do_rd);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    if (do_rd) rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_wr) wr_ptr_d = wr_ptr_q + PW'(1);
    if (wr && !do_wr) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf  = ovf_q;

endmodule : ofifo_col

// File: rtl/mac_ofifo.sv
// Purpose : output collector downstream of the MAC array. Each array column
//           has its own FIFO so skewed column completions are re-aligned;
//           a row is released only when every column holds an entry.
// Ports   : clk     - clock
//           reset   - asynchronous active-low reset
//           wr      - per-column write strobes (array valid)
//           in      - array south edge, column c at [psum_bw*c +: psum_bw]
//           rd      - pop one full row
//           out     - head row, zero while o_valid is low
//           o_valid - every column non-empty
//           o_ready - no column full
//           o_full  - some column full (inverse of o_ready)
//           o_ovf   - sticky: a write to a full column was dropped
//
// Handshake: a row transfers on any posedge where o_valid=1 and rd=1. rd
// while o_valid=0 is ignored. o_valid/o_ready/o_full come only from the
// pointers, never combinationally from wr or rd. o_ready is advisory for
// upstream; writes to a full column are dropped and flagged unless a pop
// happens in the same cycle.
module mac_ofifo
  import mac_ofifo_pkg::*;
#(
  parameter int col     = MAC_OFIFO_COL,
  parameter int psum_bw = MAC_OFIFO_PSUM_BW,
  parameter int depth   = MAC_OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [psum_bw*col-1:0] in,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_ready,
  output logic                   o_full,
  output logic                   o_ovf
);

  logic [col-1:0]         empty_vec;
  logic [col-1:0]         full_vec;
  logic [col-1:0]         ovf_vec;
  logic [psum_bw*col-1:0] head_row;
  logic                   pop;

  assign pop = rd & o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col #(
      .psum_bw (psum_bw),
      .depth   (depth)
    ) u_col (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[c]),
      .din   (in[psum_bw*c +: psum_bw]),
      .rd    (pop),
      .dout  (head_row[psum_bw*c +: psum_bw]),
      .empty (empty_vec[c]),
      .full  (full_vec[c]),
      .ovf   (ovf_vec[c])
    );
  end

  assign o_valid = ~|empty_vec;
  assign o_full  = |full_vec;
  assign o_ready = ~o_full;
  assign o_ovf   = |ovf_vec;
  assign out     = o_valid ? head_row : '0;

endmodule : mac_ofifo
